// File: rtl/mul_operand_loader.sv
// Operand feeder / result collector for the 4-bit successive-addition multiplier.
// Optional RUN-state watchdog enabled by defining MUL_TIMEOUT_EN.
module mul_operand_loader #(
  parameter int W       = 4,
  parameter int DEPTH   = 2,
  parameter int TMO_CYC = 20
) (
  input  logic         clk,
  input  logic         clrp,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] bus,
  output logic         start,
  input  logic         lda,
  input  logic         ldb,
  input  logic         done,
  input  logic [W-1:0] prod_in,
  output logic         mul_rst,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_prod,
  output logic         res_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYC < 1) begin : g_bad_cfg
    $error("mul_operand_loader: DEPTH must be a power of two >= 2, TMO_CYC >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_LOAD, S_RUN, S_BYPASS, S_RESULT, S_RECOVER
  } state_t;

  state_t        state;
  logic          byp;
  logic [W-1:0]  fa [DEPTH];
  logic [W-1:0]  fb [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          push, pop;
  logic [W-1:0]  head_a, head_b;

  assign in_ready = (cnt != CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state == S_RECOVER) | (state == S_BYPASS);
  assign head_a   = fa[rp];
  assign head_b   = fb[rp];

  // Head entry stays in place for the whole multiplication; it is only
  // released once the controller has been sent back to idle.
  assign bus = lda ? head_a : (ldb ? head_b : '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fa[wp] <= in_a;
      fb[wp] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge clrp) begin
    if (clrp) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

`ifdef MUL_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;
  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge clrp) begin
    if (clrp) begin
      state     <= S_IDLE;
      start     <= 1'b0;
      mul_rst   <= 1'b0;
      res_valid <= 1'b0;
      res_prod  <= '0;
      byp       <= 1'b0;
`ifdef MUL_TIMEOUT_EN
      tcnt      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      start   <= 1'b0;
      mul_rst <= 1'b0;
      case (state)
        S_IDLE:
          if (cnt != '0) begin
            if (head_b == '0) begin
              state <= S_BYPASS;
            end else begin
              state <= S_START;
              start <= 1'b1;
            end
          end
        S_START: state <= S_LOAD;
        S_LOAD:
          if (ldb) begin
            state <= S_RUN;
`ifdef MUL_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
        S_RUN:
          if (done) begin
            res_prod  <= prod_in;
            res_valid <= 1'b1;
            byp       <= 1'b0;
            state     <= S_RESULT;
`ifdef MUL_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (tcnt == TW'(TMO_CYC - 1)) begin
            res_prod  <= '0;
            res_valid <= 1'b1;
            byp       <= 1'b0;
            err_q     <= 1'b1;
            state     <= S_RESULT;
          end else begin
            tcnt      <= tcnt + TW'(1);
`endif
          end
        S_BYPASS: begin
          res_prod  <= '0;
          res_valid <= 1'b1;
          byp       <= 1'b1;
          state     <= S_RESULT;
`ifdef MUL_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
        end
        S_RESULT:
          if (res_ready) begin
            res_valid <= 1'b0;
            if (byp) begin
              state <= S_IDLE;
            end else begin
              mul_rst <= 1'b1;
              state   <= S_RECOVER;
            end
          end
        S_RECOVER: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mul_operand_loader.md
Name: mul_operand_loader

Overview:
- Upstream feeder and result collector for the 4-bit successive-addition multiplier datapath and its controller.
- Queues operand pairs (A, B) from a producer over a valid/ready handshake and starts one multiplication at a time.
- Drives A, then B, onto the shared operand bus on the controller's lda/ldb strobes, captures the product when done rises, and returns it over a valid/ready result port.
- Pulses mul_rst after each result to return the multiplier controller to idle.

Parameters:
- W, 4, operand/product width in bits; matches the datapath bus.
- DEPTH, 2, operand FIFO entries; power of two, >=2.
- TMO_CYC, 20, RUN-state cycle limit; used only with MUL_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- clrp  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  W  multiplicand.
- in_b  in  W  multiplier (repeat count).
- bus  out  W  operand bus to the datapath.
- start  out  1  one-cycle start pulse to the multiplier controller.
- lda  in  1  controller strobe: accumulator loads from bus.
- ldb  in  1  controller strobe: count register loads from bus.
- done  in  1  controller done, level.
- prod_in  in  W  datapath product register.
- mul_rst  out  1  one-cycle pulse returning the controller to idle.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_prod  out  W  product, mod 2^W.
- res_err  out  1  result invalid (timeout); always 0 without MUL_TIMEOUT_EN.

Behaviour:
- Reset (clrp=1, async): FIFO empty, state IDLE. start=0, mul_rst=0, res_valid=0, res_prod=0, res_err=0. in_ready is combinational from the FIFO count, so it reads 1 after reset.
- Reset mid-operation discards the FIFO and any in-flight result. No mul_rst is generated; the system reset covers the controller.
- FIFO push: on in_valid & in_ready. Pop: only on leaving RECOVER or BYPASS.
  - When full, in_ready=0. A pop in the same cycle does not raise in_ready until the next cycle (registered count).
- bus (combinational) = head.A when lda=1; head.B when ldb=1 and lda=0; 0 otherwise.
- States:
  - IDLE: if FIFO non-empty: head.B==0 -> BYPASS, else -> START.
  - START: start=1 for exactly one cycle -> LOAD.
  - LOAD: wait for ldb to have been seen high (lda precedes it) -> RUN.
  - RUN: when done=1, latch res_prod<=prod_in, res_err<=0 -> RESULT.
  - BYPASS: res_prod<=0, res_err<=0, pop FIFO, no start -> RESULT. A zero multiplier never enters the datapath.
  - RESULT: res_valid=1; res_prod/res_err stable until res_valid & res_ready.
    - On accept: if the result came from BYPASS -> IDLE, else -> RECOVER.
  - RECOVER: mul_rst=1 one cycle, pop FIFO -> IDLE.
- Latency: a bypass result is valid 2 cycles after the entry reaches the FIFO head. A datapath result is valid 1 cycle after done rises.
- Back-to-back: a new start is issued no earlier than 1 cycle after mul_rst.
- Products exceeding 2^W-1 wrap exactly as the datapath does; no saturation, no flag.
- done asserted outside RUN: ignored.

Optional Feature:
- Macro MUL_TIMEOUT_EN.
- Defined:
  - An internal counter clears on RUN entry and increments each RUN cycle.
  - If it reaches TMO_CYC without done: res_prod<=0, res_err<=1 -> RESULT. Accept then proceeds to RECOVER (mul_rst, pop) as normal.
- Undefined: no counter; RUN waits for done indefinitely; res_err tied 0.

Test Plan:
- Push (A=3, B=5); hold res_ready=1 -> start pulses once; bus=3 during lda, 5 during ldb; res_prod=15, res_err=0; then a single mul_rst pulse.
- Push (7, 0) -> no start, no mul_rst; res_valid 2 cycles after push with res_prod=0.
- Push (5, 4) -> res_prod=4 (20 mod 16).
- Hold res_ready=0; push 3 pairs with DEPTH=2 -> in_ready=0 after 2 pushes; res_valid/res_prod stable. Release res_ready -> results 15, 0, 4 returned in push order; in_ready reasserts.
- Assert clrp during RUN -> all outputs return to reset values immediately; the FIFO is empty; a subsequent push of (2, 3) yields 6.
- With MUL_TIMEOUT_EN and done tied 0: push (2, 2) -> res_valid with res_err=1, res_prod=0 after TMO_CYC RUN cycles; mul_rst pulses after accept.
